cdc_xfer_scheduler: RTL and testbench

- Source-domain controller that shares one enable-based CDC channel (2-flop-synchronised enable plus a held data bus) between NUM_REQ requesters.
- Arbitrates round-robin among the requesters and captures the winner's word.
- Sequences the channel: data setup, then an enable pulse of fixed length, then a data-hold window, so the destination always samples a stable word.
- Runs entirely on the source clock and drives the channel's data/en inputs directly.

---
 rtl/cdc_xfer_scheduler.sv | 141 ++++++++++++++
 tb/tb_cdc_xfer_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_xfer_scheduler.sv
// Source-domain scheduler for a shared enable-based CDC channel.
// Round-robin arbitration, then setup / enable pulse / hold sequencing of the data bus.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrates whenever any req is high
// SETUP  | winner's word on sync_data, gnt pulse visible, en still low
// ASSERT | sync_en high for EN_CYCLES cycles
// HOLD   | sync_en low, data held HOLD_CYCLES cycles for synchroniser latency
module cdc_xfer_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 4,
   parameter int EN_CYCLES   = 4,
   parameter int HOLD_CYCLES = 4,
   localparam int IDW        = $clog2(NUM_REQ),
   localparam int MAXC       = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES,
   localparam int CW         = $clog2(MAXC + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [DATA_WIDTH-1:0]         sync_data_o,
   output logic                          sync_en_o,
   output logic                          busy_o,
   output logic [IDW-1:0]                cur_id_o,
   output logic                          done_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ASSERT = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IDW-1:0]        rr_q, rr_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic                  en_q, en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  found;
   logic [IDW-1:0]        win;
   int                    idx;

   // first set req at or above rr_q, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      id_d    = id_q;
      data_d  = data_q;
      gnt_d   = '0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d    = ST_SETUP;
               data_d     = req_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
               id_d       = win;
               gnt_d[win] = 1'b1;
               rr_d       = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
         end
         ST_SETUP: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
         end
         ST_ASSERT: begin
            if (cnt_q == CW'(EN_CYCLES - 1)) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // outputs are registered from the next state so they line up with it
      busy_d = (state_d != ST_IDLE);
      en_d   = (state_d == ST_ASSERT);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         id_q    <= '0;
         data_q  <= '0;
         gnt_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign sync_data_o = data_q;
   assign sync_en_o   = en_q;
   assign busy_o      = busy_q;
   assign cur_id_o    = id_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// Bench for cdc_xfer_scheduler: directed scenarios plus random traffic against a
// transfer-timeline reference model (cycles elapsed since the last grant).
module tb_cdc_xfer_scheduler;

   localparam int N    = 4;
   localparam int DW   = 4;
   localparam int EN   = 4;
   localparam int HOLD = 4;
   localparam int P    = EN + HOLD + 2;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    gnt_o;
   logic [DW-1:0]   sync_data_o;
   logic            sync_en_o;
   logic            busy_o;
   logic [1:0]      cur_id_o;
   logic            done_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: age = cycles since the grant edge (0 = idle, no transfer yet)
   int          m_age = 0;
   int          m_rr = 0;
   int          m_id = 0;
   logic [DW-1:0] m_data = '0;
   logic [N-1:0]  exp_gnt = '0;
   logic [12:0]   exp_v = '0;

   cdc_xfer_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .EN_CYCLES(EN), .HOLD_CYCLES(HOLD)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req), .req_data_i(req_data),
      .gnt_o(gnt_o), .sync_data_o(sync_data_o), .sync_en_o(sync_en_o),
      .busy_o(busy_o), .cur_id_o(cur_id_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [12:0] obs();
      return {gnt_o, sync_data_o, sync_en_o, busy_o, cur_id_o, done_o};
   endfunction

   task automatic model_outputs();
      logic en, busy, dn;
      exp_gnt = (m_age == 1) ? N'(1 << m_id) : '0;
      en      = (m_age >= 2) && (m_age <= EN + 1);
      busy    = (m_age >= 1) && (m_age <= EN + HOLD + 1);
      dn      = (m_age == P);
      exp_v   = {exp_gnt, m_data, en, busy, 2'(m_id), dn};
   endtask

   task automatic model_reset();
      m_age = 0; m_rr = 0; m_id = 0; m_data = '0;
      model_outputs();
   endtask

   // one clock edge: model consumes the inputs seen at the edge, then sample at +1
   task automatic step();
      bit found;
      int k;
      @(posedge clk_i);
      if (m_age >= 1 && m_age < P) begin
         m_age++;
      end else begin
         m_age = 0;
         found = 0;
         for (int i = 0; i < N; i++) begin
            k = (m_rr + i) % N;
            if (!found && req[k]) begin
               found  = 1;
               m_id   = k;
               m_data = req_data[k*DW +: DW];
               m_rr   = (k + 1) % N;
               m_age  = 1;
            end
         end
      end
      model_outputs();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      req     = '0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      req = '0;
      #12;
      n_checks++;
      if (obs() !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected 0", obs());
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d: got %h expected %h", c, obs(), exp_v);
         end
      end
   endtask

   task automatic test_single();
      req = 4'b0001;
      req_data = 16'h000A;
      for (int c = 1; c <= 12; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL single_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         n_checks++;
         if ({gnt_o, sync_data_o, sync_en_o, busy_o, done_o} !==
             {((c == 1) ? 4'b0001 : 4'b0000), 4'hA, 1'(c >= 2 && c <= 5), 1'(c <= 9), 1'(c == 10)}) begin
            n_fail++;
            $display("FAIL single_timeline c=%0d: got gnt=%b data=%h en=%b busy=%b done=%b",
                     c, gnt_o, sync_data_o, sync_en_o, busy_o, done_o);
         end
         if (c == 1) req = '0;
      end
   endtask

   task automatic test_round_robin();
      int ids[$];
      int dat[$];
      int cyc[$];
      int e_ids[5] = '{0, 1, 2, 3, 0};
      int e_dat[5] = '{1, 2, 3, 4, 1};
      do_reset();
      req = 4'b1111;
      req_data = 16'h4321;
      for (int c = 1; c <= 50; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL rr_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (gnt_o !== '0) begin
            ids.push_back(int'(cur_id_o));
            dat.push_back(int'(sync_data_o));
            cyc.push_back(c);
            if (ids.size() == 5) req = '0;
         end
      end
      n_checks++;
      if (ids.size() != 5) begin
         n_fail++;
         $display("FAIL rr_count: got %0d grants expected 5", ids.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ids[i] != e_ids[i] || dat[i] != e_dat[i] || cyc[i] != 1 + 10*i) begin
               n_fail++;
               $display("FAIL rr_order #%0d: got id=%0d data=%0d cycle=%0d expected %0d %0d %0d",
                        i, ids[i], dat[i], cyc[i], e_ids[i], e_dat[i], 1 + 10*i);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int ids[$];
      req = 4'b0100;
      req_data = 16'h0700;
      for (int c = 1; c <= 10; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_pre c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (c == 1) req = '0;
      end
      req = 4'b0101;
      req_data = 16'h0803;
      for (int c = 1; c <= 25; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL wrap_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (gnt_o !== '0) begin
            ids.push_back(int'(cur_id_o));
            req = req & ~gnt_o;
         end
      end
      n_checks++;
      if (ids.size() != 2 || ids[0] != 0 || ids[1] != 2) begin
         n_fail++;
         $display("FAIL wrap_order: got %0d grants first=%0d expected 0 then 2",
                  ids.size(), (ids.size() > 0) ? ids[0] : -1);
      end
   endtask

   task automatic test_data_stable();
      req = 4'b0001;
      req_data = 16'h0005;
      for (int c = 1; c <= 22; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL stable_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (c <= 10 || c == 11) begin
            n_checks++;
            if (sync_data_o !== ((c <= 10) ? 4'h5 : 4'h6)) begin
               n_fail++;
               $display("FAIL stable_data c=%0d: got %h expected %h", c, sync_data_o,
                        (c <= 10) ? 4'h5 : 4'h6);
            end
         end
         if (c == 3) req_data = 16'h0006;
         if (c == 11) req = '0;
      end
   endtask

   task automatic test_reset_mid();
      req = 4'b0001;
      req_data = 16'h0009;
      for (int c = 1; c <= 3; c++) step();
      n_checks++;
      if (sync_en_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: got en=%b expected 1", sync_en_o);
      end
      #3;
      rst_n_i = 1'b0;
      req = '0;
      #1;
      n_checks++;
      if ({sync_en_o, busy_o, gnt_o, sync_data_o, cur_id_o, done_o} !== 13'h0) begin
         n_fail++;
         $display("FAIL midrst_async: got en=%b busy=%b gnt=%b data=%h expected all 0",
                  sync_en_o, busy_o, gnt_o, sync_data_o);
      end
      model_reset();
      req = 4'b0011;
      req_data = 16'h0021;
      #2;
      rst_n_i = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (c == 1) begin
            n_checks++;
            if (gnt_o !== 4'b0001 || cur_id_o !== 2'd0) begin
               n_fail++;
               $display("FAIL midrst_prio: got gnt=%b id=%0d expected 0001 0", gnt_o, cur_id_o);
            end
         end
         req = req & ~gnt_o;
      end
   endtask

   task automatic test_pulse_ignored();
      req = 4'b0001;
      req_data = 16'($urandom);
      for (int c = 1; c <= 25; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL pulse_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         n_checks++;
         if (gnt_o[1] !== 1'b0 || (c >= 11 && busy_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL pulse_spurious c=%0d: got gnt=%b busy=%b expected no gnt1, idle",
                     c, gnt_o, busy_o);
         end
         req = (c == 4) ? 4'b0010 : 4'b0000;
      end
   endtask

   task automatic test_random();
      int waits[N];
      for (int k = 0; k < N; k++) waits[k] = 0;
      for (int c = 0; c < 400; c++) begin
         step();
         n_checks++;
         if (obs() !== exp_v) begin
            n_fail++;
            $display("FAIL random_model c=%0d: got %h expected %h", c, obs(), exp_v);
         end
         if (exp_gnt != '0) begin
            for (int k = 0; k < N; k++) begin
               if (k == m_id) waits[k] = 0;
               else if (req[k]) waits[k]++;
               n_checks++;
               if (waits[k] > N - 1) begin
                  n_fail++;
                  $display("FAIL random_fair req%0d: got wait %0d expected <= %0d", k, waits[k], N - 1);
               end
            end
         end
         for (int k = 0; k < N; k++) begin
            if (!req[k]) begin
               if ($urandom_range(3) == 0) begin
                  req[k] = 1'b1;
                  req_data[k*DW +: DW] = 4'($urandom);
               end
            end else if (exp_gnt[k]) begin
               if ($urandom_range(1) == 0) req[k] = 1'b0;
               else req_data[k*DW +: DW] = 4'($urandom);
            end
         end
      end
      req = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_data_stable();
      test_reset_mid();
      test_pulse_ignored();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
